system_top_mul_pipe: RTL and testbench
======================================

Name: system_top_mul_pipe

Overview:
Parametrised, pipelined integer multiplier for the wlanSync datapath (correlator scaling, CFO phase products, energy normalisation). Each operand's signedness is selectable per instance. Optional post-product rounding right-shift and output saturation with overflow flag. Valid/ready streaming handshake with back-pressure, so it drops directly into the system_top stream stages in place of fixed-width single-stage multipliers.

Parameters:
DIN0_WIDTH, 32, operand 0 width
DIN1_WIDTH, 26, operand 1 width
DOUT_WIDTH, 48, result width
NUM_STAGE, 3, pipeline depth in cycles (legal 1..6)
DIN0_SIGNED, 1, 1 = din0 two's complement, 0 = unsigned
DIN1_SIGNED, 0, 1 = din1 two's complement, 0 = unsigned
SHIFT, 0, arithmetic right shift applied to the full product (0..DIN0_WIDTH+DIN1_WIDTH-1)
ROUND, 0, 1 = round half up before shift (ignored when SHIFT=0)
SAT, 1, 1 = clamp to DOUT range, 0 = truncate (wrap)

Ports:
ap_clk  in  1  clock, all logic rising-edge
ap_rst  in  1  synchronous active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  block accepts operands this cycle
din0  in  DIN0_WIDTH  operand 0
din1  in  DIN1_WIDTH  operand 1
out_valid  out  1  dout/ovf valid
out_ready  in  1  downstream accepts result
dout  out  DOUT_WIDTH  scaled, rounded, saturated product
ovf  out  1  result clamped (SAT=1) or significant bits lost (SAT=0); qualified by out_valid

Behaviour:
- Reset: synchronous, active-high. Clears every stage valid bit, dout=0, ovf=0. In-flight items are discarded and never emerge. in_ready is 1 in the first cycle after ap_rst deasserts.
- Arithmetic:
  - Extend each operand by one bit: sign extension if *_SIGNED, zero extension otherwise.
  - Signed multiply into P = DIN0_WIDTH+DIN1_WIDTH+2 bits.
  - If ROUND and SHIFT>0, add 2^(SHIFT-1).
  - Arithmetic right shift by SHIFT.
  - The result is signed if DIN0_SIGNED|DIN1_SIGNED, else unsigned.
- Output range: signed [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1]; unsigned [0, 2^DOUT_WIDTH-1].
  - SAT=1: clamp to range; ovf=1 iff clamped.
  - SAT=0: keep low DOUT_WIDTH bits; ovf=1 iff the value is out of range.
  - If DOUT_WIDTH >= P-SHIFT, ovf is constant 0.
- Pipeline:
  - NUM_STAGE register stages with a global enable: adv = !out_valid | out_ready.
  - in_ready = adv (combinational). A transfer occurs when in_valid & in_ready.
  - Stage 1 registers the extended operands; the multiply is split across the middle stages (retiming allowed); the last stage registers dout/ovf. With NUM_STAGE=1, the whole datapath sits before one register.
  - Latency exactly NUM_STAGE cycles from accept to out_valid when not stalled. Throughput 1 per cycle.
  - Stage valid bits shift on adv; bubbles occupy slots. Order is strictly preserved.
- Stall: while out_valid & !out_ready, all stages, dout and ovf hold; in_ready=0 that cycle. No drop, no duplication.
- Simultaneous out_ready and in_valid with a full pipe: output retires and the new input is accepted in the same cycle.
- Reset during stall or mid-stream overrides all handshakes.

Decomposition:
- Package system_top_mul_pkg: product width function, signed/unsigned min/max constant functions, parameter legality checks (NUM_STAGE range, SHIFT < P).
- Sub-module system_top_mul_pipe_sat: combinational round/shift/clamp with ovf generation. Instantiated before the final register.

Test Plan:
- Defaults: din0=32'hFFFFFFFD (-3), din1=5, out_ready=1 -> exactly 3 cycles later dout=48'hFFFF_FFFF_FFF1 (-15), ovf=0.
- Positive saturation: din0=32'h7FFFFFFF, din1=26'h3FFFFFF -> dout=48'h7FFF_FFFF_FFFF, ovf=1. SAT=0 instance: dout = low 48 bits of the product, ovf=1.
- Negative saturation: din0=32'h80000000, din1=26'h3FFFFFF -> dout=48'h8000_0000_0000, ovf=1.
- Rounding (SHIFT=4, ROUND=1, DIN1_SIGNED=1):
  - din0=24, din1=1 -> dout=2.
  - din0=-8, din1=1 -> dout=0.
  - din0=-9, din1=1 -> dout=-1.
- Back-pressure: stream din0=1..10 with din1=2 and in_valid held high; drop out_ready for 4 cycles mid-stream -> in_ready=0 during the stall, outputs 2,4,...,20 in order, none lost or duplicated, dout stable while stalled.
- Reset mid-stream: accept 2 items, assert ap_rst for 1 cycle -> out_valid=0 and dout=0 the next cycle, neither item emerges, in_ready=1 after release.

Source files
------------

// File: rtl/system_top_mul_pkg.sv
// Shared helpers for the pipelined multiplier: product width, output range bounds
// and parameter legality.
package system_top_mul_pkg;

  localparam int WIDE = 128;
  typedef logic signed [WIDE-1:0] wide_t;

  function automatic int prod_width(int w0, int w1);
    return w0 + w1 + 2;
  endfunction

  function automatic wide_t range_max(int w, bit is_signed);
    wide_t one;
    one = {{(WIDE-1){1'b0}}, 1'b1};
    return is_signed ? (one <<< (w - 1)) - one : (one <<< w) - one;
  endfunction

  function automatic wide_t range_min(int w, bit is_signed);
    wide_t one;
    one = {{(WIDE-1){1'b0}}, 1'b1};
    return is_signed ? -(one <<< (w - 1)) : '0;
  endfunction

  // Bounds compares run at WIDE bits, so product and result must fit below it.
  function automatic bit params_ok(int num_stage, int shift, int p, int dout_w);
    return (num_stage >= 1) && (num_stage <= 6) && (shift >= 0) && (shift < p) &&
           (p < WIDE) && (dout_w >= 1) && (dout_w < WIDE);
  endfunction

endpackage

// File: rtl/system_top_mul_pipe_sat.sv
// Combinational round / arithmetic shift / clamp-or-wrap stage feeding the
// final output register, with overflow detection.
module system_top_mul_pipe_sat
  import system_top_mul_pkg::*;
#(
  parameter int P          = 60,
  parameter int DOUT_WIDTH = 48,
  parameter int SHIFT      = 0,
  parameter int ROUND      = 0,
  parameter int SAT        = 1,
  parameter bit SIGNED_OUT = 1'b1
) (
  input  logic signed [P-1:0]          prod_i,
  output logic        [DOUT_WIDTH-1:0] dout_o,
  output logic                         ovf_o
);

  localparam bit    ROUND_EN = (ROUND != 0) && (SHIFT > 0);
  localparam int    RND_SH   = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam bit    NO_OVF   = DOUT_WIDTH >= P - SHIFT;
  localparam wide_t MAX_V    = range_max(DOUT_WIDTH, SIGNED_OUT);
  localparam wide_t MIN_V    = range_min(DOUT_WIDTH, SIGNED_OUT);
  localparam logic signed [P:0] RND = ROUND_EN ? ({{P{1'b0}}, 1'b1} << RND_SH) : '0;

  logic signed [P:0] sum;
  wide_t             val;
  logic              hi;
  logic              lo;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // (which would infer a latch); blocking '=' lets sum be refined step by step.
    sum    = {prod_i[P-1], prod_i};
    dout_o = '0;
    ovf_o  = 1'b0;
    // One guard bit above the product absorbs the rounding carry.
    sum    = sum + RND;
    sum    = sum >>> SHIFT;
    val    = {{(WIDE-P-1){sum[P]}}, sum};
    hi     = val > MAX_V;
    lo     = val < MIN_V;
    dout_o = val[DOUT_WIDTH-1:0];
    if (!NO_OVF) begin
      ovf_o = hi | lo;
      if (SAT != 0) begin
        if (hi) dout_o = MAX_V[DOUT_WIDTH-1:0];
        if (lo) dout_o = MIN_V[DOUT_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/system_top_mul_pipe.sv
// Pipelined multiplier with per-operand signedness, optional rounding shift and
// saturation, behind a valid/ready stream handshake with a global stall enable.
module system_top_mul_pipe
  import system_top_mul_pkg::*;
#(
  parameter int DIN0_WIDTH  = 32,
  parameter int DIN1_WIDTH  = 26,
  parameter int DOUT_WIDTH  = 48,
  parameter int NUM_STAGE   = 3,
  parameter int DIN0_SIGNED = 1,
  parameter int DIN1_SIGNED = 0,
  parameter int SHIFT       = 0,
  parameter int ROUND       = 0,
  parameter int SAT         = 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int P          = prod_width(DIN0_WIDTH, DIN1_WIDTH);
  localparam bit SIGNED_OUT = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);

  if (!params_ok(NUM_STAGE, SHIFT, P, DOUT_WIDTH)) begin : g_bad_params
    $fatal(1, "system_top_mul_pipe: illegal NUM_STAGE/SHIFT/width combination");
  end

  logic                         adv;
  logic [NUM_STAGE-1:0]         vld_q;
  logic [NUM_STAGE-1:0]         vld_d;
  logic [DOUT_WIDTH-1:0]        dout_q;
  logic                         ovf_q;
  logic signed [DIN0_WIDTH:0]   ext0;
  logic signed [DIN1_WIDTH:0]   ext1;
  logic signed [P-1:0]          sat_in;
  logic [DOUT_WIDTH-1:0]        sat_dout;
  logic                         sat_ovf;

  assign ext0 = {(DIN0_SIGNED != 0) ? din0[DIN0_WIDTH-1] : 1'b0, din0};
  assign ext1 = {(DIN1_SIGNED != 0) ? din1[DIN1_WIDTH-1] : 1'b0, din1};

  assign out_valid = vld_q[NUM_STAGE-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign dout      = dout_q;
  assign ovf       = ovf_q;

  always_comb begin
    vld_d = vld_q;
    if (adv) begin
      vld_d[0] = in_valid;
      for (int i = 1; i < NUM_STAGE; i++) vld_d[i] = vld_q[i-1];
    end
  end

  if (NUM_STAGE == 1) begin : g_comb_mul
    assign sat_in = P'(ext0) * P'(ext1);
  end else begin : g_piped_mul
    logic signed [DIN0_WIDTH:0] op0_q;
    logic signed [DIN1_WIDTH:0] op1_q;
    logic signed [P-1:0]        prod_c;

    // NOTE: datapath registers carry no reset; the valid bits alone decide
    // whether their contents mean anything, and '<=' keeps every stage
    // sampling the pre-edge value of its predecessor.
    always_ff @(posedge ap_clk) begin
      if (adv) begin
        op0_q <= ext0;
        op1_q <= ext1;
      end
    end

    assign prod_c = P'(op0_q) * P'(op1_q);

    if (NUM_STAGE == 2) begin : g_no_delay
      assign sat_in = prod_c;
    end else begin : g_delay
      logic signed [P-1:0] prod_q [NUM_STAGE-2];

      always_ff @(posedge ap_clk) begin
        if (adv) begin
          prod_q[0] <= prod_c;
          for (int i = 1; i < NUM_STAGE - 2; i++) prod_q[i] <= prod_q[i-1];
        end
      end

      assign sat_in = prod_q[NUM_STAGE-3];
    end
  end

  system_top_mul_pipe_sat #(
    .P          (P),
    .DOUT_WIDTH (DOUT_WIDTH),
    .SHIFT      (SHIFT),
    .ROUND      (ROUND),
    .SAT        (SAT),
    .SIGNED_OUT (SIGNED_OUT)
  ) u_sat (
    .prod_i (sat_in),
    .dout_o (sat_dout),
    .ovf_o  (sat_ovf)
  );

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      vld_q  <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      vld_q <= vld_d;
      if (adv) begin
        dout_q <= sat_dout;
        ovf_q  <= sat_ovf;
      end
    end
  end

endmodule

// File: tb/tb_system_top_mul_pipe.sv
// Scoreboard bench for system_top_mul_pipe: default, wrapping and rounding
// instances driven with directed vectors and hand-computed results.
module tb_system_top_mul_pipe;

  typedef struct {
    logic [47:0] d;
    logic        o;
    int          acc;
    bit          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic [2:0]  rst;
  logic [2:0]  in_valid;
  logic [2:0]  out_ready;
  wire  [2:0]  in_ready;
  wire  [2:0]  out_valid;
  wire  [2:0]  ovf;
  logic [31:0] din0 [3];
  logic [25:0] din1 [3];
  wire  [47:0] dout [3];

  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  exp_t sb0[$];
  exp_t sb1[$];
  exp_t sb2[$];
  logic [2:0]  stall_prev = '0;
  logic [47:0] dout_prev [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  system_top_mul_pipe u_def (
    .ap_clk(clk), .ap_rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .din0(din0[0]), .din1(din1[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .dout(dout[0]), .ovf(ovf[0])
  );

  system_top_mul_pipe #(.SAT(0), .NUM_STAGE(1)) u_wrap (
    .ap_clk(clk), .ap_rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .din0(din0[1]), .din1(din1[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .dout(dout[1]), .ovf(ovf[1])
  );

  system_top_mul_pipe #(.SHIFT(4), .ROUND(1), .DIN1_SIGNED(1), .NUM_STAGE(2)) u_rnd (
    .ap_clk(clk), .ap_rst(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .din0(din0[2]), .din1(din1[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .dout(dout[2]), .ovf(ovf[2])
  );

  function automatic int lat_of(int k);
    case (k)
      0:       return 3;
      1:       return 1;
      default: return 2;
    endcase
  endfunction

  function automatic int sb_size(int k);
    case (k)
      0:       return sb0.size();
      1:       return sb1.size();
      default: return sb2.size();
    endcase
  endfunction

  task automatic sb_push(input int k, input exp_t e);
    case (k)
      0:       sb0.push_back(e);
      1:       sb1.push_back(e);
      default: sb2.push_back(e);
    endcase
  endtask

  task automatic sb_pop(input int k, output exp_t e);
    case (k)
      0:       e = sb0.pop_front();
      1:       e = sb1.pop_front();
      default: e = sb2.pop_front();
    endcase
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Holds in_valid high after acceptance so consecutive calls stream back to back.
  task automatic send(input int k, input logic [31:0] a, input logic [25:0] b,
                      input logic [47:0] ed, input logic eo, input bit lat, input bit push);
    int  waited = 0;
    bit  taken  = 1'b0;
    in_valid[k] = 1'b1;
    din0[k]     = a;
    din1[k]     = b;
    while (!taken) begin
      @(negedge clk);
      if (in_ready[k]) taken = 1'b1;
      else begin
        waited++;
        if (waited > 50) begin
          n_checks++;
          n_err++;
          $display("FAIL accept_timeout[%0d]: got no in_ready in 50 cycles, expected accept", k);
          break;
        end
      end
    end
    if (taken && push) sb_push(k, '{ed, eo, cyc, lat});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int waited = 0;
    while ((sb_size(0) + sb_size(1) + sb_size(2)) != 0 && waited < 200) begin
      @(posedge clk);
      waited++;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every output transfer and polices stalls.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (rst[k]) begin
        stall_prev[k] = 1'b0;
      end else begin
        if (out_valid[k] && !out_ready[k]) begin
          check($sformatf("stall_in_ready[%0d]", k), 64'(in_ready[k]), 64'd0);
          if (stall_prev[k]) check($sformatf("stall_hold_dout[%0d]", k), 64'(dout[k]), 64'(dout_prev[k]));
          stall_prev[k] = 1'b1;
          dout_prev[k]  = dout[k];
        end else begin
          stall_prev[k] = 1'b0;
        end
        if (out_valid[k] && out_ready[k]) begin
          if (sb_size(k) == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_out[%0d]: got dout %h, expected no output", k, dout[k]);
          end else begin
            sb_pop(k, e);
            check($sformatf("dout[%0d]", k), 64'(dout[k]), 64'(e.d));
            check($sformatf("ovf[%0d]", k), 64'(ovf[k]), 64'(e.o));
            if (e.lat) check($sformatf("latency[%0d]", k), 64'(cyc - e.acc), 64'(lat_of(k)));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 3'b111;
    in_valid  = 3'b000;
    out_ready = 3'b111;
    for (int k = 0; k < 3; k++) begin
      din0[k]      = '0;
      din1[k]      = '0;
      dout_prev[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 3'b000;

    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_out_valid[%0d]", k), 64'(out_valid[k]), 64'd0);
      check($sformatf("rst_dout[%0d]", k), 64'(dout[k]), 64'd0);
      check($sformatf("rst_ovf[%0d]", k), 64'(ovf[k]), 64'd0);
      check($sformatf("rst_in_ready[%0d]", k), 64'(in_ready[k]), 64'd1);
    end
    @(posedge clk);
    #1;

    // Default instance: signed x unsigned, saturating, 3 stages.
    send(0, 32'hFFFF_FFFD, 26'd5,        48'hFFFF_FFFF_FFF1, 1'b0, 1'b1, 1'b1);
    send(0, 32'h7FFF_FFFF, 26'h3FF_FFFF, 48'h7FFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1);
    send(0, 32'h8000_0000, 26'h3FF_FFFF, 48'h8000_0000_0000, 1'b1, 1'b1, 1'b1);
    send(0, 32'h8000_0000, 26'h001_0000, 48'h8000_0000_0000, 1'b0, 1'b1, 1'b1);
    send(0, 32'h7FFF_FFFF, 26'h001_0000, 48'h7FFF_FFFF_0000, 1'b0, 1'b1, 1'b1);
    send(0, 32'h4000_0000, 26'h002_0000, 48'h7FFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1);
    in_valid[0] = 1'b0;

    // Wrapping instance, single stage.
    send(1, 32'h7FFF_FFFF, 26'h3FF_FFFF, 48'hFFFF_7C00_0001, 1'b1, 1'b1, 1'b1);
    send(1, 32'h8000_0000, 26'h3FF_FFFF, 48'h0000_8000_0000, 1'b1, 1'b1, 1'b1);
    send(1, 32'hFFFF_FFFD, 26'd5,        48'hFFFF_FFFF_FFF1, 1'b0, 1'b1, 1'b1);
    in_valid[1] = 1'b0;

    // Rounding instance: SHIFT=4 with round half up.
    send(2, 32'd24,        26'd1, 48'd2,              1'b0, 1'b1, 1'b1);
    send(2, 32'd23,        26'd1, 48'd1,              1'b0, 1'b1, 1'b1);
    send(2, 32'hFFFF_FFF8, 26'd1, 48'd0,              1'b0, 1'b1, 1'b1);
    send(2, 32'hFFFF_FFF7, 26'd1, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1);
    in_valid[2] = 1'b0;
    drain();

    // Back-pressure: continuous stream with a 4-cycle output stall mid-way.
    fork
      begin
        for (int i = 1; i <= 10; i++) send(0, 32'(i), 26'd2, 48'(2 * i), 1'b0, 1'b0, 1'b1);
        in_valid[0] = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready[0] = 1'b1;
      end
    join
    drain();

    // Reset mid-stream: two accepted items must never emerge.
    send(0, 32'd5, 26'd5, 48'd25, 1'b0, 1'b0, 1'b0);
    send(0, 32'd6, 26'd5, 48'd30, 1'b0, 1'b0, 1'b0);
    in_valid[0] = 1'b0;
    rst[0]      = 1'b1;
    @(posedge clk);
    #1 rst[0] = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid[0]), 64'd0);
    check("midrst_dout", 64'(dout[0]), 64'd0);
    check("midrst_ovf", 64'(ovf[0]), 64'd0);
    check("midrst_in_ready", 64'(in_ready[0]), 64'd1);
    repeat (8) @(negedge clk);
    drain();

    for (int k = 0; k < 3; k++) check($sformatf("sb_left[%0d]", k), 64'(sb_size(k)), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
